// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between NUM_REQ writeback sources.
// Define REGFILE_WB_ARBITER_FWD_EN to add staged-write forwarding on two read ports.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic                  we3,
    output logic [AW-1:0]         a3,
    output logic [DW-1:0]         wd3,
`ifdef REGFILE_WB_ARBITER_FWD_EN
    input  logic [AW-1:0]         a1,
    input  logic [AW-1:0]         a2,
    input  logic [DW-1:0]         rd1_rf,
    input  logic [DW-1:0]         rd2_rf,
    output logic [DW-1:0]         rd1,
    output logic [DW-1:0]         rd2,
`endif
    output logic                  busy
);

    localparam int unsigned PW = (NUM_REQ > 2) ? 2 : 1;

    logic [PW-1:0]      ptr_q;
    logic               we3_q;
    logic [AW-1:0]      a3_q;
    logic [DW-1:0]      wd3_q;

    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      idx;
    logic               found;
    logic               handshake;
    logic [AW-1:0]      gnt_addr;
    logic [DW-1:0]      gnt_data;

    // Circular search starting at the pointer; first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    // Ready is forced low during reset; it never depends on staging since the regfile drains
    // every cycle.
    assign req_ready = rst_n ? grant : '0;
    assign handshake = |req_ready;
    assign gnt_addr  = req_addr[32'(gnt_idx)*AW +: AW];
    assign gnt_data  = req_data[32'(gnt_idx)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else if (handshake) begin
            if (32'(gnt_idx) == NUM_REQ - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_idx + 1'b1;
            end
            // x0 requests complete the handshake but never reach the regfile.
            we3_q <= (gnt_addr != '0);
            a3_q  <= gnt_addr;
            wd3_q <= gnt_data;
        end else begin
            we3_q <= 1'b0;
        end
    end

    assign we3  = we3_q;
    assign a3   = a3_q;
    assign wd3  = wd3_q;
    assign busy = (|req_valid) | we3_q;

`ifdef REGFILE_WB_ARBITER_FWD_EN
    assign rd1 = (we3_q && (a3_q == a1) && (a1 != '0)) ? wd3_q : rd1_rf;
    assign rd2 = (we3_q && (a3_q == a2) && (a2 != '0)) ? wd3_q : rd2_rf;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=2, AW=5, DW=32).
// Forwarding checks compile only when REGFILE_WB_ARBITER_FWD_EN is defined.
module tb_regfile_wb_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned AW      = 5;
    localparam int unsigned DW      = 32;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;
    logic                  we3;
    logic [AW-1:0]         a3;
    logic [DW-1:0]         wd3;
    logic                  busy;
`ifdef REGFILE_WB_ARBITER_FWD_EN
    logic [AW-1:0]         a1;
    logic [AW-1:0]         a2;
    logic [DW-1:0]         rd1_rf;
    logic [DW-1:0]         rd2_rf;
    logic [DW-1:0]         rd1;
    logic [DW-1:0]         rd2;
`endif

    int checks;
    int errors;

    logic [DW-1:0] rf [32];

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .AW     (AW),
        .DW     (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .we3      (we3),
        .a3       (a3),
        .wd3      (wd3),
`ifdef REGFILE_WB_ARBITER_FWD_EN
        .a1       (a1),
        .a2       (a2),
        .rd1_rf   (rd1_rf),
        .rd2_rf   (rd2_rf),
        .rd1      (rd1),
        .rd2      (rd2),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference regfile fed by the write port.
    always @(posedge clk) begin
        if (we3) rf[a3] <= wd3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_valid = v;
        req_addr  = {ad1, ad0};
        req_data  = {d1, d0};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", req_ready);
        end
        checks++;
        if (we3 !== 1'b0 || a3 !== '0 || wd3 !== '0) begin
            errors++; $display("FAIL reset_out got we3=%b a3=%0d wd3=%h want 0/0/0", we3, a3, wd3);
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || req_ready !== 2'b00 || we3 !== 1'b0) begin
            errors++; $display("FAIL idle got busy=%b ready=%b we3=%b want 0/00/0", busy, req_ready, we3);
        end
        // Pointer 0: requester 0 wins a tie.
        set_req(2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL reset_ptr got %b want 01", req_ready);
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_single();
        set_req(2'b10, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF);
        checks++;
        if (req_ready !== 2'b10 || busy !== 1'b1) begin
            errors++; $display("FAIL single_ready got ready=%b busy=%b want 10/1", req_ready, busy);
        end
        step();
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        checks++;
        if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF || busy !== 1'b1) begin
            errors++; $display("FAIL single_write got we3=%b a3=%0d wd3=%h busy=%b want 1/5/deadbeef/1",
                               we3, a3, wd3, busy);
        end
        step();
        checks++;
        if (we3 !== 1'b0 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF || busy !== 1'b0) begin
            errors++; $display("FAIL single_hold got we3=%b a3=%0d wd3=%h busy=%b want 0/5/deadbeef/0",
                               we3, a3, wd3, busy);
        end
    endtask

    task automatic test_rotation();
        logic [1:0]    exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [AW-1:0] exp_a   [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
        logic [DW-1:0] exp_d   [4] = '{32'h11, 32'h22, 32'h11, 32'h22};
        set_req(2'b11, 5'd3, 5'd4, 32'h11, 32'h22);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready !== exp_rdy[i]) begin
                errors++; $display("FAIL rot_grant%0d got %b want %b", i, req_ready, exp_rdy[i]);
            end
            step();
            checks++;
            if (we3 !== 1'b1 || a3 !== exp_a[i] || wd3 !== exp_d[i]) begin
                errors++; $display("FAIL rot_write%0d got we3=%b a3=%0d wd3=%h want 1/%0d/%h",
                                   i, we3, a3, wd3, exp_a[i], exp_d[i]);
            end
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        checks++;
        if (we3 !== 1'b0) begin
            errors++; $display("FAIL rot_drain got we3=%b want 0", we3);
        end
    endtask

    task automatic test_same_reg();
        set_req(2'b11, 5'd7, 5'd7, 32'hA, 32'hB);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL same_grant0 got %b want 01", req_ready);
        end
        step();
        checks++;
        if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'hA || req_ready !== 2'b10) begin
            errors++; $display("FAIL same_first got we3=%b a3=%0d wd3=%h ready=%b want 1/7/a/10",
                               we3, a3, wd3, req_ready);
        end
        step();
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        checks++;
        if (we3 !== 1'b1 || wd3 !== 32'hB) begin
            errors++; $display("FAIL same_second got we3=%b wd3=%h want 1/b", we3, wd3);
        end
        step();
        checks++;
        if (rf[7] !== 32'hB) begin
            errors++; $display("FAIL same_final got x7=%h want b", rf[7]);
        end
    endtask

    task automatic test_x0();
        rf[0] = 32'h0;
        set_req(2'b01, 5'd0, 5'd0, 32'hFFFF, 32'h0);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL x0_grant got %b want 01", req_ready);
        end
        step();
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        checks++;
        if (we3 !== 1'b0) begin
            errors++; $display("FAIL x0_we3 got %b want 0", we3);
        end
        // Pointer advanced to 1, so requester 1 wins the tie.
        set_req(2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL x0_ptr got %b want 10", req_ready);
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        checks++;
        if (rf[0] !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL x0_rf got x0=%h busy=%b want 0/0", rf[0], busy);
        end
    endtask

`ifdef REGFILE_WB_ARBITER_FWD_EN
    task automatic test_fwd();
        a1 = 5'd9; a2 = 5'd3; rd1_rf = 32'h0; rd2_rf = 32'h77;
        set_req(2'b10, 5'd0, 5'd9, 32'h0, 32'h1234);
        step();
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        checks++;
        if (rd1 !== 32'h1234 || rd2 !== 32'h77) begin
            errors++; $display("FAIL fwd_hit got rd1=%h rd2=%h want 1234/77", rd1, rd2);
        end
        a1 = 5'd0; rd1_rf = 32'h55; a2 = 5'd9;
        #1;
        checks++;
        if (rd1 !== 32'h55 || rd2 !== 32'h1234) begin
            errors++; $display("FAIL fwd_x0 got rd1=%h rd2=%h want 55/1234", rd1, rd2);
        end
        step();
        checks++;
        if (rd2 !== 32'h77) begin
            errors++; $display("FAIL fwd_idle got rd2=%h want 77", rd2);
        end
    endtask
`endif

    task automatic test_mid_reset();
        set_req(2'b11, 5'd3, 5'd4, 32'h33, 32'h44);
        step();
        checks++;
        if (we3 !== 1'b1) begin
            errors++; $display("FAIL mid_staged got we3=%b want 1", we3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (we3 !== 1'b0 || req_ready !== 2'b00 || a3 !== '0 || wd3 !== '0) begin
            errors++; $display("FAIL mid_reset got we3=%b ready=%b a3=%0d wd3=%h want 0/00/0/0",
                               we3, req_ready, a3, wd3);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL mid_ptr got %b want 01", req_ready);
        end
        set_req(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef REGFILE_WB_ARBITER_FWD_EN
        a1 = '0; a2 = '0; rd1_rf = '0; rd2_rf = '0;
`endif
        #2;
        test_reset();
        test_single();
        test_rotation();
        test_same_reg();
        test_x0();
`ifdef REGFILE_WB_ARBITER_FWD_EN
        test_fwd();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single regfile write port (we3/a3/wd3) between NUM_REQ writeback sources, e.g. ALU, LSU load return and CSR unit.
- Round-robin arbitration with a valid/ready handshake on each requester.
- The winning write is staged in one output register that drives the regfile write port. Throughput is one write per cycle.
- Sits between the execute/memory writeback stages and the regfile.

Parameters:
- NUM_REQ, 2, number of writeback requesters; legal range 2..4.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  grant; handshake completes when valid&ready at posedge clk.
- req_addr  input  NUM_REQ*AW  destination register; requester i occupies bits [i*AW +: AW].
- req_data  input  NUM_REQ*DW  write data; requester i occupies bits [i*DW +: DW].
- we3  output  1  regfile write enable (registered).
- a3  output  AW  regfile write address (registered).
- wd3  output  DW  regfile write data (registered).
- busy  output  1  any req_valid asserted or staged write pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - we3=0, a3=0, wd3=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - All req_ready=0 while reset is asserted.
- Arbitration (combinational, same cycle as request):
  - Among asserted req_valid bits, grant the first index at or after the pointer, searching circularly.
  - Exactly one req_ready is high when any req_valid is high; all are low otherwise.
  - req_ready never asserts for a requester whose valid is low.
- Pointer update:
  - On a completed handshake by requester g, pointer <= (g+1) mod NUM_REQ.
  - No handshake: pointer holds.
- Staging:
  - The cycle after a handshake, we3=1 with a3/wd3 equal to the granted addr/data.
  - No handshake: we3=0; a3/wd3 hold their previous values.
  - Latency from handshake to regfile write edge: 1 cycle.
  - The staging register always drains, because the regfile accepts every cycle. req_ready therefore never depends on staging state.
- x0 writes:
  - A request with addr=0 is arbitrated and handshaken normally and advances the pointer.
  - The staged cycle drives we3=0, so x0 is never written.
- Requester protocol:
  - A requester holds valid, addr and data stable until ready.
  - Dropping valid before ready is permitted; the request is simply not performed.
- Simultaneous writes to the same register:
  - Served in grant order, one per cycle.
  - The later grant's data is the final regfile value.
- Single requester continuously valid, others idle: it is granted every cycle (full throughput).
- All requesters continuously valid: strict rotation 0,1,..,NUM_REQ-1,0. Maximum wait for any requester is NUM_REQ-1 cycles.
- Reset asserted mid-operation: a staged write not yet clocked into the regfile is discarded (we3 forced 0 immediately).
- busy = |req_valid | we3.

Optional Feature:
- Macro: REGFILE_WB_ARBITER_FWD_EN.
- When defined, these ports are added:
  - a1, a2  input  AW  read addresses.
  - rd1_rf, rd2_rf  input  DW  regfile read data.
  - rd1, rd2  output  DW  forwarded read data.
- Forwarding rule: rdN = wd3 when we3=1 and a3==aN and aN!=0; otherwise rdN = rdN_rf.
  - Purely combinational; covers the cycle where a write is staged but not yet in the regfile.
- When not defined, none of these ports exist and no forwarding logic is built. Readers see regfile contents only, one cycle after the staged write.

Test Plan:
- Reset release, no requests -> we3=0, all req_ready=0, busy=0, pointer 0.
- Only req 1 valid with addr=5, data=0xDEADBEEF -> req_ready=2'b10 same cycle; next cycle we3=1, a3=5, wd3=0xDEADBEEF; then we3=0.
- NUM_REQ=2, both valid for 4 cycles with addr 3/4 and data 0x11/0x22 -> grants 0,1,0,1; we3 sequence writes x3,x4,x3,x4 at one-cycle lag.
- Both valid, both addr=7, data 0xA/0xB, pointer 0 -> x7 written 0xA, then 0xB; final regfile x7=0xB.
- Req 0 addr=0, data=0xFFFF -> handshake completes, pointer advances to 1, next cycle we3=0.
- With REGFILE_WB_ARBITER_FWD_EN: staged write x9=0x1234, a1=9, rd1_rf=0 -> rd1=0x1234. Same case with a1=0 -> rd1=rd1_rf.
- rst_n pulsed low while we3=1 -> we3 drops asynchronously, pointer resets to 0.
